// File: rtl/mma_pkg.sv
// Shared types and constants for the matrix-engine tile scheduler.
// Holds the scheduler state enum, the err_code encodings and the tile command struct.
// SA_SIZE falls back to 16 unless define.svh or the build supplies it first.
`ifndef SA_SIZE
`define SA_SIZE 16
`endif

package mma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } mma_state_e;

  localparam logic [1:0] MMA_ERR_OK       = 2'b00;
  localparam logic [1:0] MMA_ERR_ZERO_DIM = 2'b01;
  localparam logic [1:0] MMA_ERR_BUS      = 2'b10;

  localparam int MMA_REG_WIDTH = 32;
  localparam int MMA_DIM_WIDTH = $clog2(`SA_SIZE) + 1;

  // One tile command as seen by the array datapath (default build widths).
  typedef struct packed {
    logic [MMA_REG_WIDTH-1:0] lhs;
    logic [MMA_REG_WIDTH-1:0] rhs;
    logic [MMA_REG_WIDTH-1:0] dst;
    logic [MMA_REG_WIDTH-1:0] n;
    logic [MMA_DIM_WIDTH-1:0] rows;
    logic [MMA_DIM_WIDTH-1:0] cols;
    logic                     last;
  } mma_tile_cmd_t;

endpackage

// File: rtl/mma_tile_cnt.sv
// 2-D tile walker: row/column indices plus running tile addresses, adders only.
// Ports: load_i latches config and rewinds to tile (0,0); step_i advances one tile row-major.
// Outputs are registered current-tile fields; rows/cols/last are derived from the remaining extent.
`ifndef SA_SIZE
`define SA_SIZE 16
`endif

module mma_tile_cnt
  import mma_pkg::*;
#(
  parameter int SIZE      = `SA_SIZE,
  parameter int REG_WIDTH = MMA_REG_WIDTH,
  localparam int DIM_W    = $clog2(SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [REG_WIDTH-1:0] k_i,
  input  logic [REG_WIDTH-1:0] m_i,
  input  logic [REG_WIDTH-1:0] lhs_base_i,
  input  logic [REG_WIDTH-1:0] rhs_base_i,
  input  logic [REG_WIDTH-1:0] dst_base_i,
  input  logic [REG_WIDTH-1:0] lhs_stride_i,
  input  logic [REG_WIDTH-1:0] rhs_stride_i,
  input  logic [REG_WIDTH-1:0] dst_stride_i,
  output logic [REG_WIDTH-1:0] lhs_addr_o,
  output logic [REG_WIDTH-1:0] rhs_addr_o,
  output logic [REG_WIDTH-1:0] dst_addr_o,
  output logic [DIM_W-1:0]     rows_o,
  output logic [DIM_W-1:0]     cols_o,
  output logic                 last_o
);

  localparam int                   LOG2   = $clog2(SIZE);
  localparam logic [REG_WIDTH-1:0] SIZE_R = REG_WIDTH'(SIZE);

  logic [REG_WIDTH-1:0] k_q, k_d, m_q, m_d;
  logic [REG_WIDTH-1:0] rhs_base_q, rhs_base_d;
  // Strides are pre-shifted by log2(SIZE) at load so each step is a plain add.
  logic [REG_WIDTH-1:0] lhs_stp_q, lhs_stp_d, rhs_stp_q, rhs_stp_d, dst_stp_q, dst_stp_d;
  logic [REG_WIDTH-1:0] row_q, row_d, col_q, col_d;
  logic [REG_WIDTH-1:0] lhs_q, lhs_d, rhs_q, rhs_d;
  logic [REG_WIDTH-1:0] dst_row_q, dst_row_d, dst_q, dst_d;

  logic [REG_WIDTH-1:0] rem_k, rem_m, dst_row_nxt;
  logic                 row_more, col_more;

  // row/col always stay below k/m while a tile is current, so the unsigned
  // difference is the true remaining extent.
  assign rem_k       = k_q - row_q;
  assign rem_m       = m_q - col_q;
  assign row_more    = rem_k > SIZE_R;
  assign col_more    = rem_m > SIZE_R;
  assign dst_row_nxt = dst_row_q + dst_stp_q;

  assign rows_o     = row_more ? DIM_W'(SIZE) : rem_k[DIM_W-1:0];
  assign cols_o     = col_more ? DIM_W'(SIZE) : rem_m[DIM_W-1:0];
  assign last_o     = !row_more && !col_more;
  assign lhs_addr_o = lhs_q;
  assign rhs_addr_o = rhs_q;
  assign dst_addr_o = dst_q;

  always_comb begin
    k_d        = k_q;
    m_d        = m_q;
    rhs_base_d = rhs_base_q;
    lhs_stp_d  = lhs_stp_q;
    rhs_stp_d  = rhs_stp_q;
    dst_stp_d  = dst_stp_q;
    row_d      = row_q;
    col_d      = col_q;
    lhs_d      = lhs_q;
    rhs_d      = rhs_q;
    dst_row_d  = dst_row_q;
    dst_d      = dst_q;
    if (load_i) begin
      k_d        = k_i;
      m_d        = m_i;
      rhs_base_d = rhs_base_i;
      lhs_stp_d  = lhs_stride_i << LOG2;
      rhs_stp_d  = rhs_stride_i << LOG2;
      dst_stp_d  = dst_stride_i << LOG2;
      row_d      = '0;
      col_d      = '0;
      lhs_d      = lhs_base_i;
      rhs_d      = rhs_base_i;
      dst_row_d  = dst_base_i;
      dst_d      = dst_base_i;
    end else if (step_i) begin
      if (col_more) begin
        // Next tile along M: B advances by SIZE rows, output by SIZE bytes.
        col_d = col_q + SIZE_R;
        rhs_d = rhs_q + rhs_stp_q;
        dst_d = dst_q + SIZE_R;
      end else begin
        // Wrap to the next tile row: B rewinds, A and output rows advance.
        col_d     = '0;
        row_d     = row_q + SIZE_R;
        lhs_d     = lhs_q + lhs_stp_q;
        rhs_d     = rhs_base_q;
        dst_row_d = dst_row_nxt;
        dst_d     = dst_row_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      m_q        <= '0;
      rhs_base_q <= '0;
      lhs_stp_q  <= '0;
      rhs_stp_q  <= '0;
      dst_stp_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      lhs_q      <= '0;
      rhs_q      <= '0;
      dst_row_q  <= '0;
      dst_q      <= '0;
    end else begin
      k_q        <= k_d;
      m_q        <= m_d;
      rhs_base_q <= rhs_base_d;
      lhs_stp_q  <= lhs_stp_d;
      rhs_stp_q  <= rhs_stp_d;
      dst_stp_q  <= dst_stp_d;
      row_q      <= row_d;
      col_q      <= col_d;
      lhs_q      <= lhs_d;
      rhs_q      <= rhs_d;
      dst_row_q  <= dst_row_d;
      dst_q      <= dst_d;
    end
  end

endmodule

// File: rtl/mma_tile_sched.sv
// Tile scheduler: latches CSR config on calc_start, issues SIZExSIZE tile commands, reports err_code.
// Latency: first tile_valid 2 cycles after start; zero-dim wb_valid 2 cycles after start.
// Backpressure: tile_valid/tile_ready and wb_valid/wb_ready; issue throttled at MAX_OUTS outstanding.
// Ports: calc_start/sa_ready (dispatch), k/m/n/bases/strides (CSR), tile_* (array), wb_valid/wb_ready/err_code (WBU).
// Optional macro MMA_TILE_SCHED_PERF_EN adds perf_cycles (busy cycles) and perf_tiles (issued tiles).
`ifndef SA_SIZE
`define SA_SIZE 16
`endif

module mma_tile_sched
  import mma_pkg::*;
#(
  parameter int SIZE      = `SA_SIZE,
  parameter int REG_WIDTH = MMA_REG_WIDTH,
  parameter int MAX_OUTS  = 2,
  localparam int DIM_W    = $clog2(SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 calc_start,
  output logic                 sa_ready,
  input  logic [REG_WIDTH-1:0] k,
  input  logic [REG_WIDTH-1:0] m,
  input  logic [REG_WIDTH-1:0] n,
  input  logic [REG_WIDTH-1:0] lhs_base,
  input  logic [REG_WIDTH-1:0] rhs_base,
  input  logic [REG_WIDTH-1:0] dst_base,
  input  logic [REG_WIDTH-1:0] lhs_row_stride_b,
  input  logic [REG_WIDTH-1:0] rhs_row_stride_b,
  input  logic [REG_WIDTH-1:0] dst_row_stride_b,
  output logic                 tile_valid,
  input  logic                 tile_ready,
  output logic [REG_WIDTH-1:0] tile_lhs_addr,
  output logic [REG_WIDTH-1:0] tile_rhs_addr,
  output logic [REG_WIDTH-1:0] tile_dst_addr,
  output logic [DIM_W-1:0]     tile_rows,
  output logic [DIM_W-1:0]     tile_cols,
  output logic [REG_WIDTH-1:0] tile_n,
  output logic                 tile_last,
  input  logic                 tile_done,
  input  logic                 tile_err,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [1:0]           err_code
`ifdef MMA_TILE_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [15:0]          perf_tiles
`endif
);

  localparam int OUT_W = 3;

  mma_state_e           state_q, state_d;
  logic [REG_WIDTH-1:0] n_q, n_d;
  logic                 zero_q, zero_d;
  logic [OUT_W-1:0]     outs_q, outs_d;
  logic                 sticky_q, sticky_d;
  logic [1:0]           err_q, err_d;

  logic start_acc, tile_hs, done_acc, cnt_load, cnt_last;

  assign start_acc = (state_q == ST_IDLE) && calc_start;
  assign tile_valid = (state_q == ST_ISSUE) && (outs_q < OUT_W'(MAX_OUTS)) && !sticky_q;
  assign tile_hs   = tile_valid && tile_ready;
  // A completion with nothing outstanding is stale (e.g. from before a reset).
  assign done_acc  = tile_done && (outs_q != '0);
  assign cnt_load  = start_acc;

  assign tile_n    = n_q;
  assign tile_last = cnt_last && tile_valid;
  assign err_code  = err_q;

  mma_tile_cnt #(
    .SIZE      (SIZE),
    .REG_WIDTH (REG_WIDTH)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .load_i       (cnt_load),
    .step_i       (tile_hs),
    .k_i          (k),
    .m_i          (m),
    .lhs_base_i   (lhs_base),
    .rhs_base_i   (rhs_base),
    .dst_base_i   (dst_base),
    .lhs_stride_i (lhs_row_stride_b),
    .rhs_stride_i (rhs_row_stride_b),
    .dst_stride_i (dst_row_stride_b),
    .lhs_addr_o   (tile_lhs_addr),
    .rhs_addr_o   (tile_rhs_addr),
    .dst_addr_o   (tile_dst_addr),
    .rows_o       (tile_rows),
    .cols_o       (tile_cols),
    .last_o       (cnt_last)
  );

  // Outstanding count and sticky bus error.
  always_comb begin
    outs_d   = outs_q;
    sticky_d = sticky_q;
    n_d      = n_q;
    zero_d   = zero_q;
    if (start_acc) begin
      outs_d   = '0;
      sticky_d = 1'b0;
      n_d      = n;
      zero_d   = (k == '0) || (m == '0) || (n == '0);
    end else begin
      case ({tile_hs, done_acc})
        2'b10:   outs_d = outs_q + 1'b1;
        2'b01:   outs_d = outs_q - 1'b1;
        default: outs_d = outs_q;
      endcase
      if (done_acc && tile_err) begin
        sticky_d = 1'b1;
      end
    end
  end

  // Control FSM.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    sa_ready = 1'b0;
    wb_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sa_ready = 1'b1;
        if (calc_start) begin
          err_d   = MMA_ERR_OK;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (zero_q) begin
          err_d   = MMA_ERR_ZERO_DIM;
          state_d = ST_RESP;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // An error arriving this cycle ends issue as well as one already latched.
        if (sticky_d || (tile_hs && cnt_last)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outs_q == '0) begin
          err_d   = sticky_q ? MMA_ERR_BUS : MMA_ERR_OK;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      zero_q   <= 1'b0;
      outs_q   <= '0;
      sticky_q <= 1'b0;
      err_q    <= MMA_ERR_OK;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      zero_q   <= zero_d;
      outs_q   <= outs_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
    end
  end

`ifdef MMA_TILE_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_tiles_q, perf_tiles_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_tiles_d  = perf_tiles_q;
    if (start_acc) begin
      perf_cycles_d = '0;
      perf_tiles_d  = '0;
    end else begin
      if ((state_q != ST_IDLE) && (perf_cycles_q != '1)) begin
        perf_cycles_d = perf_cycles_q + 32'd1;
      end
      if (tile_hs && (perf_tiles_q != '1)) begin
        perf_tiles_d = perf_tiles_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_tiles_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_tiles_q  <= perf_tiles_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_tiles  = perf_tiles_q;
`endif

endmodule

// File: tb/tb_mma_tile_sched.sv
// Directed bench for mma_tile_sched with a tile scoreboard and a completion responder.
module tb_mma_tile_sched;
  import mma_pkg::*;

  localparam int SIZE = 16;
  localparam int RW   = 32;
  localparam int DW   = $clog2(SIZE) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          calc_start;
  logic          sa_ready;
  logic [RW-1:0] k, m, n, lhs_base, rhs_base, dst_base;
  logic [RW-1:0] lhs_row_stride_b, rhs_row_stride_b, dst_row_stride_b;
  logic          tile_valid, tile_ready;
  logic [RW-1:0] tile_lhs_addr, tile_rhs_addr, tile_dst_addr, tile_n;
  logic [DW-1:0] tile_rows, tile_cols;
  logic          tile_last, tile_done, tile_err;
  logic          wb_valid, wb_ready;
  logic [1:0]    err_code;
`ifdef MMA_TILE_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_tiles;
`endif

  always #5 clk = ~clk;

  mma_tile_sched #(.SIZE(SIZE), .REG_WIDTH(RW), .MAX_OUTS(2)) dut (
    .clk(clk), .rst(rst), .calc_start(calc_start), .sa_ready(sa_ready),
    .k(k), .m(m), .n(n),
    .lhs_base(lhs_base), .rhs_base(rhs_base), .dst_base(dst_base),
    .lhs_row_stride_b(lhs_row_stride_b), .rhs_row_stride_b(rhs_row_stride_b),
    .dst_row_stride_b(dst_row_stride_b),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_lhs_addr(tile_lhs_addr), .tile_rhs_addr(tile_rhs_addr), .tile_dst_addr(tile_dst_addr),
    .tile_rows(tile_rows), .tile_cols(tile_cols), .tile_n(tile_n), .tile_last(tile_last),
    .tile_done(tile_done), .tile_err(tile_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .err_code(err_code)
`ifdef MMA_TILE_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_tiles(perf_tiles)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mma_tile_cmd_t exp_q[$];
  int            due_q[$];
  bit            auto_done = 1'b0;
  bit            man_done_req = 1'b0;
  int            err_on_done = 0;
  int            done_idx = 0;
  bit            err_seen = 1'b0;
  int            err_edge = 0;
  int            late_issue = 0;
  int            hs_count = 0;
  bit            chk_stable = 1'b0;
  bit            prev_stall = 1'b0;
  logic [RW-1:0] prev_lhs, prev_rhs, prev_dst;
  logic [RW-1:0] cap_rhs[0:7];
  logic [RW-1:0] cap_dst[0:7];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Completion responder and tile scoreboard. Runs just after each falling
  // edge so the main sequence's input changes on that edge are already settled.
  initial begin
    mma_tile_cmd_t e;
    tile_done = 1'b0;
    tile_err  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      tile_done = 1'b0;
      tile_err  = 1'b0;
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        done_idx++;
        tile_done = 1'b1;
        if (done_idx == err_on_done) begin
          tile_err = 1'b1;
          err_seen = 1'b1;
          err_edge = cyc + 1;
        end
      end
      if (man_done_req) begin
        tile_done    = 1'b1;
        man_done_req = 1'b0;
      end
      if (chk_stable && prev_stall) begin
        chk("stall_valid", 64'(tile_valid), 64'd1);
        chk("stall_lhs_rhs", {tile_lhs_addr, tile_rhs_addr}, {prev_lhs, prev_rhs});
        chk("stall_dst", 64'(tile_dst_addr), 64'(prev_dst));
      end
      prev_stall = tile_valid && !tile_ready;
      prev_lhs   = tile_lhs_addr;
      prev_rhs   = tile_rhs_addr;
      prev_dst   = tile_dst_addr;
      if (tile_valid && tile_ready) begin
        if (err_seen && (cyc + 1 > err_edge)) late_issue++;
        if (hs_count < 8) begin
          cap_rhs[hs_count] = tile_rhs_addr;
          cap_dst[hs_count] = tile_dst_addr;
        end
        hs_count++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL tile_unexpected: observed lhs=%0h with no tile expected", tile_lhs_addr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tile_lhs",  64'(tile_lhs_addr), 64'(e.lhs));
          chk("tile_rhs",  64'(tile_rhs_addr), 64'(e.rhs));
          chk("tile_dst",  64'(tile_dst_addr), 64'(e.dst));
          chk("tile_n",    64'(tile_n),        64'(e.n));
          chk("tile_rows", 64'(tile_rows),     64'(e.rows));
          chk("tile_cols", 64'(tile_cols),     64'(e.cols));
          chk("tile_last", 64'(tile_last),     64'(e.last));
        end
        if (auto_done) due_q.push_back(cyc + 3);
      end
    end
  end

  // Reference walk written directly from the tile geometry.
  task automatic push_tiles(input int unsigned kk, input int unsigned mm, input int unsigned nn,
                            input int unsigned lb, input int unsigned rb, input int unsigned db,
                            input int unsigned ls, input int unsigned rs, input int unsigned ds);
    mma_tile_cmd_t e;
    for (int unsigned r = 0; r < kk; r += SIZE) begin
      for (int unsigned c = 0; c < mm; c += SIZE) begin
        e.lhs  = lb + r * ls;
        e.rhs  = rb + c * rs;
        e.dst  = db + r * ds + c;
        e.n    = nn;
        e.rows = DW'((kk - r > SIZE) ? SIZE : kk - r);
        e.cols = DW'((mm - c > SIZE) ? SIZE : mm - c);
        e.last = (r + SIZE >= kk) && (c + SIZE >= mm);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_job(input int unsigned kk, input int unsigned mm, input int unsigned nn,
                           input int unsigned lb, input int unsigned rb, input int unsigned db,
                           input int unsigned ls, input int unsigned rs, input int unsigned ds,
                           input bit zero);
    k = kk; m = mm; n = nn;
    lhs_base = lb; rhs_base = rb; dst_base = db;
    lhs_row_stride_b = ls; rhs_row_stride_b = rs; dst_row_stride_b = ds;
    calc_start = 1'b1;
    @(negedge clk);
    calc_start = 1'b0;
    // Scramble the config: only the values latched at start may be used.
    k = $urandom; m = $urandom; n = 0;
    lhs_base = $urandom; rhs_base = $urandom; dst_base = $urandom;
    lhs_row_stride_b = $urandom; rhs_row_stride_b = $urandom; dst_row_stride_b = $urandom;
    chk("start_sa_ready_low", 64'(sa_ready), 64'd0);
    chk("start_no_valid_c1", 64'(tile_valid), 64'd0);
    @(negedge clk);
    if (zero) begin
      chk("zero_wb_valid_c2", 64'(wb_valid), 64'd1);
      chk("zero_no_tile", 64'(tile_valid), 64'd0);
    end else begin
      chk("first_valid_c2", 64'(tile_valid), 64'd1);
    end
  endtask

  task automatic wait_wb(input logic [1:0] exp_err, input string tag, input bit rnd_ready);
    int cnt = 0;
    while (!wb_valid && cnt < 3000) begin
      if (rnd_ready) tile_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cnt++;
    end
    tile_ready = 1'b1;
    chk({tag, "_wb_arrived"}, 64'(wb_valid), 64'd1);
    if (wb_valid) begin
      chk({tag, "_err"}, 64'(err_code), 64'(exp_err));
      repeat (2) @(negedge clk);
      chk({tag, "_wb_hold"}, {62'd0, wb_valid, 1'b1}, 64'd3);
      chk({tag, "_err_hold"}, 64'(err_code), 64'(exp_err));
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      chk({tag, "_idle_ready"}, 64'(sa_ready), 64'd1);
      chk({tag, "_wb_dropped"}, 64'(wb_valid), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; calc_start = 1'b0; tile_ready = 1'b0; wb_ready = 1'b0;
    k = 0; m = 0; n = 0; lhs_base = 0; rhs_base = 0; dst_base = 0;
    lhs_row_stride_b = 0; rhs_row_stride_b = 0; dst_row_stride_b = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_sa_ready", 64'(sa_ready), 64'd1);
    chk("rst_tile_valid", 64'(tile_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_tile_last", 64'(tile_last), 64'd0);
    chk("rst_addrs", {tile_lhs_addr, tile_dst_addr}, 64'd0);
    chk("rst_dims", {tile_rows, tile_cols, tile_n}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single full tile
    auto_done = 1'b1; tile_ready = 1'b1; hs_count = 0;
    push_tiles(16, 16, 8, 'h100, 'h200, 'h300, 16, 16, 16);
    start_job(16, 16, 8, 'h100, 'h200, 'h300, 16, 16, 16, 1'b0);
    wait_wb(MMA_ERR_OK, "one_tile", 1'b0);
    chk("one_tile_count", 64'(hs_count), 64'd1);
    chk("one_tile_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef MMA_TILE_SCHED_PERF_EN
    chk("perf_tiles_one", 64'(perf_tiles), 64'd1);
`endif

    // 20x40 walk with random tile_ready, plus a start pulse while busy
    hs_count = 0; chk_stable = 1'b1;
    push_tiles(20, 40, 8, 'h1000, 'h2000, 'h3000, 8, 8, 40);
    start_job(20, 40, 8, 'h1000, 'h2000, 'h3000, 8, 8, 40, 1'b0);
    calc_start = 1'b1;
    @(negedge clk);
    calc_start = 1'b0;
    wait_wb(MMA_ERR_OK, "walk", 1'b1);
    chk_stable = 1'b0; prev_stall = 1'b0;
    chk("walk_count", 64'(hs_count), 64'd6);
    chk("walk_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("walk_t5_dst", 64'(cap_dst[4]), 64'h3000 + 64'd656);
    chk("walk_t5_rhs", 64'(cap_rhs[4]), 64'h2000 + 64'd128);

    // Outstanding limit with completions withheld
    hs_count = 0; auto_done = 1'b0; tile_ready = 1'b1;
    push_tiles(20, 40, 5, 'h40, 'h80, 'hC0, 4, 4, 40);
    start_job(20, 40, 5, 'h40, 'h80, 'hC0, 4, 4, 40, 1'b0);
    repeat (2) @(negedge clk);
    chk("outs_two_issued", 64'(hs_count), 64'd2);
    chk("outs_throttled", 64'(tile_valid), 64'd0);
    @(negedge clk);
    chk("outs_still_throttled", 64'(tile_valid), 64'd0);
    man_done_req = 1'b1;
    @(negedge clk);
    chk("outs_reissue_valid", 64'(tile_valid), 64'd1);
    @(negedge clk);
    chk("outs_third_issued", 64'(hs_count), 64'd3);
    chk("outs_throttled_again", 64'(tile_valid), 64'd0);
    auto_done = 1'b1;
    man_done_req = 1'b1;
    @(negedge clk);
    man_done_req = 1'b1;
    @(negedge clk);
    wait_wb(MMA_ERR_OK, "outs", 1'b0);
    chk("outs_count", 64'(hs_count), 64'd6);
    chk("outs_sb_empty", 64'(exp_q.size()), 64'd0);

    // Zero dimension
    hs_count = 0;
    start_job(16, 16, 0, 'h10, 'h20, 'h30, 16, 16, 16, 1'b1);
    wait_wb(MMA_ERR_ZERO_DIM, "zero", 1'b0);
    chk("zero_no_tiles", 64'(hs_count), 64'd0);

    // Bus error on the second completion
    hs_count = 0; done_idx = 0; err_on_done = 2; err_seen = 1'b0; late_issue = 0;
    push_tiles(20, 40, 8, 'h1000, 'h2000, 'h3000, 8, 8, 40);
    start_job(20, 40, 8, 'h1000, 'h2000, 'h3000, 8, 8, 40, 1'b0);
    wait_wb(MMA_ERR_BUS, "buserr", 1'b0);
    chk("buserr_seen", 64'(err_seen), 64'd1);
    chk("buserr_no_late_issue", 64'(late_issue), 64'd0);
    chk("buserr_truncated", 64'(hs_count >= 2 && hs_count <= 3), 64'd1);
    exp_q.delete();
    err_on_done = 0;

    // Reset during issue with one tile outstanding
    hs_count = 0; auto_done = 1'b0; tile_ready = 1'b0;
    push_tiles(16, 40, 8, 'h500, 'h600, 'h700, 16, 16, 16);
    start_job(16, 40, 8, 'h500, 'h600, 'h700, 16, 16, 16, 1'b0);
    tile_ready = 1'b1;
    @(negedge clk);
    tile_ready = 1'b0;
    chk("rstmid_one_issued", 64'(hs_count), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_sa_ready", 64'(sa_ready), 64'd1);
    chk("rstmid_valids", {62'd0, tile_valid, wb_valid}, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    due_q.delete();
    man_done_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_late_done_idle", 64'(sa_ready), 64'd1);
    hs_count = 0; auto_done = 1'b1; tile_ready = 1'b1;
    push_tiles(16, 16, 8, 'h100, 'h200, 'h300, 16, 16, 16);
    start_job(16, 16, 8, 'h100, 'h200, 'h300, 16, 16, 16, 1'b0);
    wait_wb(MMA_ERR_OK, "after_rst", 1'b0);
    chk("after_rst_count", 64'(hs_count), 64'd1);
    chk("after_rst_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
